// File: rtl/riscv_pkg.sv
// Shared types for the instruction-memory loader and its helpers.
// Exports: loader_state_t, WORD_BYTES, HDR_BYTES.
package riscv_pkg;

  typedef enum logic [2:0] {
    HDR_LO,
    HDR_HI,
    DATA,
    CSUM,
    DONE,
    ERROR
  } loader_state_t;

  localparam int WORD_BYTES = 4;
  localparam int HDR_BYTES  = 2;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// byte_packer: assembles little-endian words from a byte stream.
// Ports: clk, rst, clr, shift_en, byte_in -> word, word_valid, word_last.
module byte_packer
  import riscv_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    shift_en,
  input  logic [7:0]              byte_in,
  output logic [8*WORD_BYTES-1:0] word,
  output logic                    word_valid,
  output logic                    word_last
);

  localparam int LW = $clog2(WORD_BYTES);
  localparam logic [LW-1:0] LAST_LANE = LW'(WORD_BYTES - 1);

  logic [LW-1:0] lane;

  // Combinational: this shift completes a word.
  assign word_last = shift_en && (lane == LAST_LANE);

  always_ff @(posedge clk) begin
    if (rst) begin
      lane       <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= word_last;
      if (clr) begin
        lane <= '0;
      end else if (shift_en) begin
        word[{lane, 3'b000} +: 8] <= byte_in;
        lane <= lane + 1'b1;
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: frames a byte stream into imem writes, holds core in reset.
// Ports: byte_valid/byte_data/byte_ready, reload, imem_*, cpu_rst, done, error.
// Option: IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
module imem_loader
  import riscv_pkg::*;
#(
  parameter int          ADDR_WIDTH = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  input  logic        reload,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_rst,
  output logic        done,
  output logic        error
);

  localparam int IW = ADDR_WIDTH + 1;
  localparam logic [31:0] CAP = 32'd1 << ADDR_WIDTH;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam loader_state_t TAIL_ST = CSUM;
`else
  localparam loader_state_t TAIL_ST = DONE;
`endif

  loader_state_t state, state_nx;

  logic [7:0]    n_lo;
  logic [15:0]   n_q;
  logic [15:0]   n_hdr;
  logic [IW-1:0] word_idx;
  logic          xfer;
  logic          last_word;
  logic          pk_shift;
  logic          pk_last;
  logic          running;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] csum;
`endif

  assign xfer      = byte_valid & byte_ready;
  assign n_hdr     = {byte_data, n_lo};
  assign last_word = (32'(word_idx) + 32'd1) == 32'(n_q);
  assign pk_shift  = xfer && (state == DATA);
  assign imem_addr = BASE_ADDR + (32'(word_idx) * 32'(WORD_BYTES));

  byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clr        (state == HDR_LO),
    .shift_en   (pk_shift),
    .byte_in    (byte_data),
    .word       (imem_wdata),
    .word_valid (imem_we),
    .word_last  (pk_last)
  );

  always_comb begin
    state_nx = state;
    unique case (state)
      HDR_LO: if (xfer) state_nx = HDR_HI;
      HDR_HI: begin
        if (xfer) begin
          if (n_hdr == 16'd0)
            state_nx = TAIL_ST;
          else if (32'(n_hdr) > CAP)
            state_nx = ERROR;
          else
            state_nx = DATA;
        end
      end
      DATA: if (pk_last && last_word) state_nx = TAIL_ST;
      CSUM: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (xfer)
          state_nx = (byte_data == csum) ? DONE : ERROR;
`else
        state_nx = ERROR;
`endif
      end
      DONE:  if (reload) state_nx = HDR_LO;
      ERROR: if (reload) state_nx = HDR_LO;
      default: state_nx = ERROR;
    endcase
  end

  // DONE is entered on the last byte; the write lands one cycle later,
  // so the core is released only once DONE has been held a full cycle.
  assign running = (state == DONE) && (state_nx == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= HDR_LO;
      byte_ready <= 1'b0;
      cpu_rst    <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
      n_lo       <= '0;
      n_q        <= '0;
      word_idx   <= '0;
    end else begin
      state      <= state_nx;
      byte_ready <= state_nx inside {HDR_LO, HDR_HI, DATA, CSUM};
      cpu_rst    <= !running;
      done       <= running;
      error      <= (state_nx == ERROR);
      if (imem_we)
        word_idx <= word_idx + 1'b1;
      if (state == HDR_LO) begin
        word_idx <= '0;
        if (xfer) n_lo <= byte_data;
      end
      if ((state == HDR_HI) && xfer)
        n_q <= n_hdr;
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst)
      csum <= '0;
    else if (state == HDR_LO)
      csum <= '0;
    else if (pk_shift)
      csum <= csum ^ byte_data;
  end
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader (ADDR_WIDTH=2, BASE_ADDR=0).
// Covers streaming, stalls, empty/oversized headers, rst, reload, checksum.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        reload;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_rst;
  logic        done;
  logic        error;

  always #5 clk = ~clk;

  imem_loader #(
    .ADDR_WIDTH (2),
    .BASE_ADDR  (32'h0000_0000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .reload     (reload),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_rst    (cpu_rst),
    .done       (done),
    .error      (error)
  );

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam int CS_DLY = 2;
`else
  localparam int CS_DLY = 1;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wr_n = 0;
  logic [31:0] wr_addr [64];
  logic [31:0] wr_data [64];
  int wr_cyc [64];
  int fall_cyc = -1;
  logic cpu_rst_d = 1'b1;
  int last_xfer = 0;
  int xc [64];
  logic [7:0] fq [$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (imem_we && wr_n < 64) begin
      wr_addr[wr_n] = imem_addr;
      wr_data[wr_n] = imem_wdata;
      wr_cyc[wr_n]  = cyc;
      wr_n++;
    end
    if (cpu_rst_d && !cpu_rst) fall_cyc = cyc;
    cpu_rst_d = cpu_rst;
  end

  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    byte_data  = b;
    byte_valid = 1'b1;
    while (!byte_ready && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (!byte_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout byte %h", b);
    end
    last_xfer = cyc + 1;
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic send_frame(input bit gap, input logic [7:0] flip);
    logic [7:0] x;
    x = 8'h00;
    for (int i = 0; i < fq.size(); i++) begin
      send_byte(fq[i]);
      xc[i] = last_xfer;
      if (i >= 2) x ^= fq[i];
      if (gap) @(negedge clk);
    end
    x ^= flip;
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(x);
`endif
  endtask

  task automatic pulse_reload;
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
  endtask

  task automatic apply_reset;
    rst = 1'b1;
    byte_valid = 1'b0;
    byte_data = 8'h00;
    reload = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    byte_valid = 1'b0;
    byte_data = 8'h5A;
    reload = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (byte_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_ready got %b want 0", byte_ready);
    end
    checks++;
    if (imem_we !== 1'b0) begin
      errors++;
      $display("FAIL rst_we got %b want 0", imem_we);
    end
    checks++;
    if (imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL rst_addr got %h want 0", imem_addr);
    end
    checks++;
    if (imem_wdata !== 32'h0) begin
      errors++;
      $display("FAIL rst_wdata got %h want 0", imem_wdata);
    end
    checks++;
    if ({cpu_rst, done, error} !== 3'b100) begin
      errors++;
      $display("FAIL rst_flags got %b want 100",
               {cpu_rst, done, error});
    end
    reload = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (byte_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_ready_up got %b want 1", byte_ready);
    end
  endtask

  task automatic test_stream;
    int b;
    apply_reset();
    b = wr_n;
    fq = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0,
           8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
    send_frame(1'b0, 8'h00);
    repeat (4) @(negedge clk);
    checks++;
    if (wr_n - b !== 2) begin
      errors++;
      $display("FAIL s_count got %0d want 2", wr_n - b);
    end
    checks++;
    if (wr_addr[b] !== 32'h0 || wr_data[b] !== 32'h00A00513) begin
      errors++;
      $display("FAIL s_w0 got %h/%h want 0/00a00513",
               wr_addr[b], wr_data[b]);
    end
    checks++;
    if (wr_addr[b+1] !== 32'h4 || wr_data[b+1] !== 32'h00100593) begin
      errors++;
      $display("FAIL s_w1 got %h/%h want 4/00100593",
               wr_addr[b+1], wr_data[b+1]);
    end
    checks++;
    if (fall_cyc - wr_cyc[b+1] !== CS_DLY) begin
      errors++;
      $display("FAIL s_release got %0d want %0d",
               fall_cyc - wr_cyc[b+1], CS_DLY);
    end
    checks++;
    if ({done, cpu_rst, byte_ready, error} !== 4'b1000) begin
      errors++;
      $display("FAIL s_final got %b want 1000",
               {done, cpu_rst, byte_ready, error});
    end
  endtask

  task automatic test_stall;
    int b;
    apply_reset();
    b = wr_n;
    fq = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0,
           8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
    send_frame(1'b1, 8'h00);
    repeat (4) @(negedge clk);
    checks++;
    if (wr_n - b !== 2) begin
      errors++;
      $display("FAIL st_count got %0d want 2", wr_n - b);
    end
    checks++;
    if (wr_data[b] !== 32'h00A00513 || wr_data[b+1] !== 32'h00100593) begin
      errors++;
      $display("FAIL st_data got %h/%h want 00a00513/00100593",
               wr_data[b], wr_data[b+1]);
    end
    checks++;
    if (wr_cyc[b] !== xc[5] || wr_cyc[b+1] !== xc[9]) begin
      errors++;
      $display("FAIL st_latency got %0d/%0d want %0d/%0d",
               wr_cyc[b], wr_cyc[b+1], xc[5], xc[9]);
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL st_done got %b want 1", done);
    end
  endtask

  task automatic test_empty;
    int b;
    apply_reset();
    b = wr_n;
    fq = '{8'h00, 8'h00};
    send_frame(1'b0, 8'h00);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL e_done_early got %b want 0", done);
    end
    @(negedge clk);
    checks++;
    if ({done, cpu_rst, byte_ready} !== 3'b100) begin
      errors++;
      $display("FAIL e_done got %b want 100",
               {done, cpu_rst, byte_ready});
    end
    repeat (3) @(negedge clk);
    checks++;
    if (wr_n - b !== 0) begin
      errors++;
      $display("FAIL e_writes got %0d want 0", wr_n - b);
    end
  endtask

  task automatic test_oversize;
    int b;
    apply_reset();
    b = wr_n;
    send_byte(8'h05);
    send_byte(8'h00);
    checks++;
    if ({error, byte_ready, cpu_rst, done} !== 4'b1010) begin
      errors++;
      $display("FAIL o_err got %b want 1010",
               {error, byte_ready, cpu_rst, done});
    end
    repeat (3) @(negedge clk);
    checks++;
    if (wr_n - b !== 0 || error !== 1'b1) begin
      errors++;
      $display("FAIL o_sticky got %0d/%b want 0/1", wr_n - b, error);
    end
    pulse_reload();
    checks++;
    if ({error, byte_ready, cpu_rst} !== 3'b011) begin
      errors++;
      $display("FAIL o_reload got %b want 011",
               {error, byte_ready, cpu_rst});
    end
  endtask

  task automatic test_full;
    int b;
    apply_reset();
    b = wr_n;
    fq = '{8'h04, 8'h00};
    for (int i = 0; i < 16; i++) fq.push_back(8'(i));
    send_frame(1'b0, 8'h00);
    repeat (4) @(negedge clk);
    checks++;
    if (wr_n - b !== 4) begin
      errors++;
      $display("FAIL f_count got %0d want 4", wr_n - b);
    end
    checks++;
    if (wr_data[b] !== 32'h03020100) begin
      errors++;
      $display("FAIL f_w0 got %h want 03020100", wr_data[b]);
    end
    checks++;
    if (wr_addr[b+3] !== 32'hC || wr_data[b+3] !== 32'h0F0E0D0C) begin
      errors++;
      $display("FAIL f_w3 got %h/%h want c/0f0e0d0c",
               wr_addr[b+3], wr_data[b+3]);
    end
    checks++;
    if ({done, error} !== 2'b10) begin
      errors++;
      $display("FAIL f_done got %b want 10", {done, error});
    end
  endtask

  task automatic test_rst_mid;
    int b;
    logic [7:0] part [8];
    apply_reset();
    b = wr_n;
    part = '{8'h02, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
    for (int i = 0; i < 8; i++) send_byte(part[i]);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({byte_ready, imem_we, cpu_rst} !== 3'b001) begin
      errors++;
      $display("FAIL r_in_rst got %b want 001",
               {byte_ready, imem_we, cpu_rst});
    end
    rst = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (wr_n - b !== 1 || wr_data[b] !== 32'hDDCCBBAA) begin
      errors++;
      $display("FAIL r_partial got %0d/%h want 1/ddccbbaa",
               wr_n - b, wr_data[b]);
    end
    fq = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
    send_frame(1'b0, 8'h00);
    repeat (4) @(negedge clk);
    checks++;
    if (wr_n - b !== 2 || wr_addr[b+1] !== 32'h0) begin
      errors++;
      $display("FAIL r_fresh_addr got %0d/%h want 2/0",
               wr_n - b, wr_addr[b+1]);
    end
    checks++;
    if (wr_data[b+1] !== 32'h12345678 || done !== 1'b1) begin
      errors++;
      $display("FAIL r_fresh_data got %h/%b want 12345678/1",
               wr_data[b+1], done);
    end
  endtask

  task automatic test_reload;
    int b;
    b = wr_n;
    pulse_reload();
    checks++;
    if ({done, cpu_rst, byte_ready} !== 3'b011) begin
      errors++;
      $display("FAIL rl_state got %b want 011",
               {done, cpu_rst, byte_ready});
    end
    fq = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    send_frame(1'b0, 8'h00);
    repeat (4) @(negedge clk);
    checks++;
    if (wr_n - b !== 1 || wr_addr[b] !== 32'h0) begin
      errors++;
      $display("FAIL rl_addr got %0d/%h want 1/0", wr_n - b, wr_addr[b]);
    end
    checks++;
    if (wr_data[b] !== 32'hDEADBEEF || done !== 1'b1) begin
      errors++;
      $display("FAIL rl_data got %h/%b want deadbeef/1",
               wr_data[b], done);
    end
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_checksum;
    apply_reset();
    fq = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    send_frame(1'b0, 8'h00);
    repeat (3) @(negedge clk);
    checks++;
    if ({done, error} !== 2'b10) begin
      errors++;
      $display("FAIL c_match got %b want 10", {done, error});
    end
    pulse_reload();
    send_frame(1'b0, 8'h01);
    repeat (3) @(negedge clk);
    checks++;
    if ({done, error, cpu_rst} !== 3'b011) begin
      errors++;
      $display("FAIL c_mismatch got %b want 011",
               {done, error, cpu_rst});
    end
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_empty();
    test_oversize();
    test_full();
    test_rst_mid();
    test_reload();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
